// File: rtl/ace_ccu_conflict_sched_pkg.sv
// ace_ccu_conflict_sched_pkg: scheduler state encoding and round-robin pointer values
package ace_ccu_conflict_sched_pkg;
  typedef logic [1:0] ccu_sched_state_t;
  localparam ccu_sched_state_t IDLE   = 2'd0;
  localparam ccu_sched_state_t GNT_AR = 2'd1;
  localparam ccu_sched_state_t GNT_AW = 2'd2;
  localparam logic RR_AR = 1'b0;
  localparam logic RR_AW = 1'b1;
endpackage

// File: rtl/ace_ccu_conflict_sched_if.sv
// ace_ccu_conflict_sched_if: AR/AW request handshakes between demux, scheduler and ccu_fsm
interface ace_ccu_conflict_sched_if #(
  parameter int AddrWidth = 64,
  parameter int IdWidth   = 5
);
  logic                 slv_ar_valid, slv_ar_ready, mst_ar_valid, mst_ar_ready;
  logic [AddrWidth-1:0] slv_ar_addr;
  logic [IdWidth-1:0]   slv_ar_id;
  logic                 slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
  logic [AddrWidth-1:0] slv_aw_addr;
  logic [IdWidth-1:0]   slv_aw_id;
  modport master (
    output slv_ar_valid, slv_ar_addr, slv_ar_id, mst_ar_ready,
    output slv_aw_valid, slv_aw_addr, slv_aw_id, mst_aw_ready,
    input  slv_ar_ready, mst_ar_valid, slv_aw_ready, mst_aw_valid
  );
  modport slave (
    input  slv_ar_valid, slv_ar_addr, slv_ar_id, mst_ar_ready,
    input  slv_aw_valid, slv_aw_addr, slv_aw_id, mst_aw_ready,
    output slv_ar_ready, mst_ar_valid, slv_aw_ready, mst_aw_valid
  );
endinterface

// File: rtl/ace_ccu_conflict_sched_table.sv
// ace_ccu_conflict_sched_table: outstanding-transaction table with line/ID conflict lookup,
// lowest-free-slot allocation, completion invalidation and occupancy count.
module ace_ccu_conflict_sched_table #(
  parameter int MaxTrans  = 8,
  parameter int LineWidth = 58,
  parameter int IdWidth   = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [LineWidth-1:0]        ar_line,
  input  logic [IdWidth-1:0]          ar_id,
  input  logic [LineWidth-1:0]        aw_line,
  input  logic [IdWidth-1:0]          aw_id,
  output logic                        ar_ok,
  output logic                        aw_ok,
  output logic                        full,
  input  logic                        alloc,
  input  logic                        alloc_write,
  input  logic [LineWidth-1:0]        alloc_line,
  input  logic [IdWidth-1:0]          alloc_id,
  input  logic                        r_done,
  input  logic [IdWidth-1:0]          r_done_id,
  input  logic                        b_done,
  input  logic [IdWidth-1:0]          b_done_id,
  output logic [$clog2(MaxTrans):0]   count,
  output logic                        err
);
  localparam int IdxW = $clog2(MaxTrans);
  typedef struct packed {
    logic                 valid;
    logic                 is_write;
    logic [LineWidth-1:0] line;
    logic [IdWidth-1:0]   id;
  } entry_t;
  entry_t tab_q [MaxTrans];
  logic [MaxTrans-1:0] vld, ar_line_hit, aw_line_hit, ar_id_hit, aw_id_hit, r_hit, b_hit, clr;
  logic [IdxW-1:0] free_idx;
  logic miss;
  for (genvar i = 0; i < MaxTrans; i++) begin : g_match
    assign vld[i]         = tab_q[i].valid;
    assign ar_line_hit[i] = vld[i] && tab_q[i].line == ar_line;
    assign aw_line_hit[i] = vld[i] && tab_q[i].line == aw_line;
    assign ar_id_hit[i]   = vld[i] && !tab_q[i].is_write && tab_q[i].id == ar_id;
    assign aw_id_hit[i]   = vld[i] && tab_q[i].is_write && tab_q[i].id == aw_id;
    assign r_hit[i]       = vld[i] && !tab_q[i].is_write && tab_q[i].id == r_done_id;
    assign b_hit[i]       = vld[i] && tab_q[i].is_write && tab_q[i].id == b_done_id;
  end
  assign ar_ok = ~|{ar_line_hit, ar_id_hit};
  assign aw_ok = ~|{aw_line_hit, aw_id_hit};
  assign full  = &vld;
  assign clr   = (r_done ? r_hit : '0) | (b_done ? b_hit : '0);
  assign miss  = (r_done && !(|r_hit)) || (b_done && !(|b_hit));
  always_comb begin
    free_idx = '0;
    count    = '0;
    for (int i = MaxTrans - 1; i >= 0; i--) free_idx = vld[i] ? free_idx : IdxW'(i);
    for (int i = 0; i < MaxTrans; i++) count = count + (IdxW+1)'(vld[i]);
  end
  // Slot choice uses pre-free occupancy, so a same-cycle free never collides with the new entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MaxTrans; i++) tab_q[i] <= '0;
      err <= 1'b0;
    end else begin
      for (int i = 0; i < MaxTrans; i++) if (clr[i]) tab_q[i].valid <= 1'b0;
      if (alloc) tab_q[free_idx] <= '{valid: 1'b1, is_write: alloc_write, line: alloc_line, id: alloc_id};
      err <= err | miss;
    end
  end
endmodule

// File: rtl/ace_ccu_conflict_sched.sv
// ace_ccu_conflict_sched: serializes coherent AR/AW issue to one outstanding transaction per line,
// round-robin between AR and AW; ACE_CCU_CONFLICT_STATS_EN adds a saturating stall counter.
module ace_ccu_conflict_sched
  import ace_ccu_conflict_sched_pkg::*;
#(
  parameter int MaxTrans  = 8,
  parameter int AddrWidth = 64,
  parameter int IdWidth   = 5,
  parameter int LineBytes = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  ace_ccu_conflict_sched_if.slave   bus,
  input  logic                      r_done_i,
  input  logic [IdWidth-1:0]        r_done_id_i,
  input  logic                      b_done_i,
  input  logic [IdWidth-1:0]        b_done_id_i,
  output logic                      busy_o,
  output logic [$clog2(MaxTrans):0] count_o,
  output logic                      err_o
`ifdef ACE_CCU_CONFLICT_STATS_EN
  ,
  output logic [31:0]               stall_cnt_o,
  input  logic                      stall_clr_i
`endif
);
  localparam int OffW  = $clog2(LineBytes);
  localparam int LineW = AddrWidth - OffW;
  ccu_sched_state_t state_q, state_d;
  logic rr_q, ar_ok, aw_ok, full, ar_elig, aw_elig, hs_ar, hs_aw, alloc, gnt_valid, unused_off;
  logic [LineW-1:0] ar_line, aw_line;
  assign ar_line    = bus.slv_ar_addr[AddrWidth-1:OffW];
  assign aw_line    = bus.slv_aw_addr[AddrWidth-1:OffW];
  assign unused_off = ^{bus.slv_ar_addr[OffW-1:0], bus.slv_aw_addr[OffW-1:0]};
  assign ar_elig    = bus.slv_ar_valid && !full && ar_ok;
  assign aw_elig    = bus.slv_aw_valid && !full && aw_ok;
  assign bus.mst_ar_valid = state_q == GNT_AR && bus.slv_ar_valid;
  assign bus.slv_ar_ready = state_q == GNT_AR && bus.mst_ar_ready;
  assign bus.mst_aw_valid = state_q == GNT_AW && bus.slv_aw_valid;
  assign bus.slv_aw_ready = state_q == GNT_AW && bus.mst_aw_ready;
  assign hs_ar      = bus.mst_ar_valid && bus.mst_ar_ready;
  assign hs_aw      = bus.mst_aw_valid && bus.mst_aw_ready;
  assign alloc      = hs_ar || hs_aw;
  assign gnt_valid  = state_q == GNT_AR ? bus.slv_ar_valid : state_q == GNT_AW ? bus.slv_aw_valid : 1'b0;
  always_comb begin
    state_d = state_q == IDLE ? (ar_elig && (!aw_elig || rr_q == RR_AR) ? GNT_AR : aw_elig ? GNT_AW : IDLE)
            : (alloc || !gnt_valid) ? IDLE : state_q;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= RR_AR;
    end else begin
      state_q <= state_d;
      if (alloc) rr_q <= hs_ar ? RR_AW : RR_AR;
    end
  end
  ace_ccu_conflict_sched_table #(
    .MaxTrans (MaxTrans),
    .LineWidth(LineW),
    .IdWidth  (IdWidth)
  ) u_table (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ar_line    (ar_line),
    .ar_id      (bus.slv_ar_id),
    .aw_line    (aw_line),
    .aw_id      (bus.slv_aw_id),
    .ar_ok      (ar_ok),
    .aw_ok      (aw_ok),
    .full       (full),
    .alloc      (alloc),
    .alloc_write(hs_aw),
    .alloc_line (hs_aw ? aw_line : ar_line),
    .alloc_id   (hs_aw ? bus.slv_aw_id : bus.slv_ar_id),
    .r_done     (r_done_i),
    .r_done_id  (r_done_id_i),
    .b_done     (b_done_i),
    .b_done_id  (b_done_id_i),
    .count      (count_o),
    .err        (err_o)
  );
  assign busy_o = |count_o;
`ifdef ACE_CCU_CONFLICT_STATS_EN
  logic stall;
  assign stall = (bus.slv_ar_valid && !ar_elig) || (bus.slv_aw_valid && !aw_elig);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_cnt_o <= '0;
    else if (stall_clr_i) stall_cnt_o <= '0;
    else if (stall && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_ace_ccu_conflict_sched.sv
// tb_ace_ccu_conflict_sched: directed bench for the AR/AW conflict scheduler
module tb_ace_ccu_conflict_sched;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  ace_ccu_conflict_sched_if #(.AddrWidth(64), .IdWidth(5)) bus ();
  logic r_done = 1'b0, b_done = 1'b0, busy, err;
  logic [4:0] r_id = '0, b_id = '0;
  logic [3:0] count;
`ifdef ACE_CCU_CONFLICT_STATS_EN
  logic [31:0] stall_cnt;
  logic stall_clr = 1'b0;
`endif
  ace_ccu_conflict_sched dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus),
    .r_done_i   (r_done),
    .r_done_id_i(r_id),
    .b_done_i   (b_done),
    .b_done_id_i(b_id),
    .busy_o     (busy),
    .count_o    (count),
    .err_o      (err)
`ifdef ACE_CCU_CONFLICT_STATS_EN
    ,
    .stall_cnt_o(stall_cnt),
    .stall_clr_i(stall_clr)
`endif
  );
  int errors = 0, checks = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.slv_ar_valid = 0; bus.slv_ar_addr = '0; bus.slv_ar_id = '0; bus.mst_ar_ready = 0;
    bus.slv_aw_valid = 0; bus.slv_aw_addr = '0; bus.slv_aw_id = '0; bus.mst_aw_ready = 0;
    tick; tick;
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ar_valid", bus.mst_ar_valid, 0);
    chk("rst_ar_ready", bus.slv_ar_ready, 0);
    rst_n = 1;
    tick;
    // lone AR: one idle cycle, then granted
    bus.slv_ar_valid = 1; bus.slv_ar_addr = 64'h1000; bus.slv_ar_id = 3; bus.mst_ar_ready = 1;
    #1 chk("t1_idle_valid", bus.mst_ar_valid, 0);
    tick;
    chk("t1_gnt_valid", bus.mst_ar_valid, 1);
    chk("t1_gnt_ready", bus.slv_ar_ready, 1);
    tick;
    bus.slv_ar_valid = 0;
    chk("t1_count", count, 1);
    chk("t1_busy", busy, 1);
    // AW on the same line waits for the read; an unrelated AR still goes
    bus.slv_aw_valid = 1; bus.slv_aw_addr = 64'h1020; bus.slv_aw_id = 1; bus.mst_aw_ready = 1;
    tick; tick;
    chk("t2_aw_blocked", bus.mst_aw_valid, 0);
    bus.slv_ar_valid = 1; bus.slv_ar_addr = 64'h5000; bus.slv_ar_id = 4;
    tick;
    chk("t2_ar_bypass", bus.mst_ar_valid, 1);
    chk("t2_aw_held", bus.mst_aw_valid, 0);
    tick;
    bus.slv_ar_valid = 0;
    chk("t2_count2", count, 2);
    r_done = 1; r_id = 3;
    tick;
    r_done = 0;
    chk("t2_count_free", count, 1);
    chk("t2_aw_idle", bus.mst_aw_valid, 0);
    tick;
    chk("t2_aw_gnt", bus.mst_aw_valid, 1);
    tick;
    bus.slv_aw_valid = 0;
    chk("t2_count_aw", count, 2);
    r_done = 1; r_id = 4; b_done = 1; b_id = 1;
    tick;
    r_done = 0; b_done = 0;
    chk("t2_dual_free", count, 0);
    chk("t2_err", err, 0);
    // both channels busy: AR, AW, AR, AW at one grant per two cycles
    bus.slv_ar_valid = 1; bus.slv_ar_addr = 64'h2000; bus.slv_ar_id = 0;
    bus.slv_aw_valid = 1; bus.slv_aw_addr = 64'h3000; bus.slv_aw_id = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_idle_ar", bus.mst_ar_valid, 0);
      chk("t3_idle_aw", bus.mst_aw_valid, 0);
      tick;
      chk("t3_gnt_ar", bus.mst_ar_valid, (k % 2) == 0);
      chk("t3_gnt_aw", bus.mst_aw_valid, (k % 2) == 1);
      tick;
      if (k % 2 == 0) begin
        bus.slv_ar_addr += 64'h40; bus.slv_ar_id++;
      end else begin
        bus.slv_aw_addr += 64'h40; bus.slv_aw_id++;
      end
    end
    bus.slv_ar_valid = 0; bus.slv_aw_valid = 0;
    chk("t3_count", count, 4);
    // fill the table, then a ninth AR stalls
    bus.slv_ar_valid = 1; bus.slv_ar_addr = 64'h4000; bus.slv_ar_id = 2;
    for (int k = 0; k < 4; k++) begin
      tick; tick;
      bus.slv_ar_addr += 64'h40; bus.slv_ar_id++;
    end
    chk("t4_full", count, 8);
    tick; tick;
    chk("t4_stall", bus.mst_ar_valid, 0);
    chk("t4_count_stall", count, 8);
    bus.mst_ar_ready = 0; b_done = 1; b_id = 0;
    tick;
    b_done = 0;
    chk("t4_count_free", count, 7);
    tick;
    chk("t4_gnt_valid", bus.mst_ar_valid, 1);
    chk("t4_gnt_wait", bus.slv_ar_ready, 0);
    bus.mst_ar_ready = 1; r_done = 1; r_id = 0;
    #1 chk("t4_gnt_ready", bus.slv_ar_ready, 1);
    tick;
    r_done = 0; bus.slv_ar_addr = 64'h4140; bus.slv_ar_id = 7;
    chk("t4_alloc_free", count, 7);
    tick; tick;
    bus.slv_ar_valid = 0;
    chk("t4_refill", count, 8);
    chk("t4_err", err, 0);
    // completion with no matching entry
    b_done = 1; b_id = 7;
    tick;
    b_done = 0;
    chk("t5_err", err, 1);
    chk("t5_count", count, 8);
    tick; tick;
    chk("t5_err_sticky", err, 1);
    // async reset while granting AW with entries outstanding
    b_done = 1; b_id = 1;
    bus.slv_aw_valid = 1; bus.slv_aw_addr = 64'h6000; bus.slv_aw_id = 2; bus.mst_aw_ready = 0;
    tick;
    b_done = 0;
    chk("t6_count", count, 7);
    tick;
    chk("t6_gnt_aw", bus.mst_aw_valid, 1);
    rst_n = 0; bus.mst_aw_ready = 1;
    #1;
    chk("t6_count_rst", count, 0);
    chk("t6_busy_rst", busy, 0);
    chk("t6_aw_valid_rst", bus.mst_aw_valid, 0);
    chk("t6_aw_ready_rst", bus.slv_aw_ready, 0);
    chk("t6_err_rst", err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
